// File: rtl/global_ram_ofm_reader_if.sv
// Global RAM read port and OFM byte stream bundled for the OFM reader.
// master: reader side (drives rd_en/rd_addr, m_valid/m_data/m_last); slave: RAM + sink side.
interface global_ram_ofm_reader_if #(
  parameter int ADDR_W = 32
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [127:0]      rd_data;
  logic              m_valid;
  logic              m_ready;
  logic [7:0]        m_data;
  logic              m_last;

  modport master (
    output rd_en, rd_addr, m_valid, m_data, m_last,
    input  rd_data, m_ready
  );

  modport slave (
    input  rd_en, rd_addr, m_valid, m_data, m_last,
    output rd_data, m_ready
  );
endinterface

// File: rtl/global_ram_ofm_reader.sv
// Reads a byte range of global RAM word by word and unpacks it into a byte stream.
// Ports: clk, reset_n, start/base_addr/size in, busy/done out, bus = RAM read port + byte stream.
module global_ram_ofm_reader #(
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1,
  parameter int FIFO_D = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] size,
  global_ram_ofm_reader_if.master bus,
  output logic              busy,
  output logic              done
);

  localparam int PW = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int CW = $clog2(FIFO_D + 1);
  localparam logic [CW:0] DEPTH = (CW + 1)'(FIFO_D);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] words_q;
  logic [ADDR_W-1:0] bytes_q;
  logic [3:0]        idx_q;
  logic [RD_LAT-1:0] pipe_q;
  logic [127:0]      mem_q [FIFO_D];
  logic [PW-1:0]     wp_q, rp_q;
  logic [CW-1:0]     cnt_q;

  logic [CW-1:0] infl;
  logic [CW:0]   credit;
  logic          issue, push, valid, hs, last, pop;
  logic [127:0]  head;
  logic [7:0]    byte_w;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FIFO_D - 1)) ? '0 : p + 1'b1;
  endfunction

  // Reads still travelling through the RAM count against FIFO space
  always_comb begin
    infl = '0;
    for (int i = 0; i < RD_LAT; i++) infl = infl + CW'(pipe_q[i]);
  end

  assign credit = {1'b0, cnt_q} + {1'b0, infl};
  assign issue  = (state_q == RUN) && (words_q != '0)
                  && (credit < DEPTH);
  assign push   = pipe_q[RD_LAT-1];
  assign valid  = (state_q == RUN) && (cnt_q != '0);
  assign head   = mem_q[rp_q];
  assign byte_w = head[{idx_q, 3'b000} +: 8];
  assign hs     = valid && bus.m_ready;
  assign last   = (bytes_q == ADDR_W'(1));
  assign pop    = hs && ((idx_q == 4'hF) || last);

  // Data gated by valid so every stream output reads 0 out of reset
  assign bus.rd_en   = issue;
  assign bus.rd_addr = addr_q;
  assign bus.m_valid = valid;
  assign bus.m_data  = valid ? byte_w : '0;
  assign bus.m_last  = valid && last;

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = (size == '0) ? FIN : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (hs && last) state_d = FIN;
      end
      FIN: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      words_q <= '0;
      bytes_q <= '0;
      idx_q   <= '0;
      pipe_q  <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;

      if (state_q == IDLE && start) begin
        addr_q  <= base_addr >> 4;
        words_q <= (size >> 4) + ADDR_W'(|size[3:0]);
        bytes_q <= size;
      end else begin
        if (issue) begin
          addr_q  <= addr_q + 1'b1;
          words_q <= words_q - 1'b1;
        end
        if (hs) bytes_q <= bytes_q - 1'b1;
      end

      if (pop)     idx_q <= '0;
      else if (hs) idx_q <= idx_q + 1'b1;

      pipe_q[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];

      if (push) wp_q <= nxt(wp_q);
      if (pop)  rp_q <= nxt(rp_q);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  // Word storage needs no reset; count and pointers define occupancy
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= bus.rd_data;
  end

endmodule
